rgb2gray_frame_ctrl: RTL and testbench
======================================

Name: rgb2gray_frame_ctrl

Overview:
Sequencer and BRAM-port arbiter for the RGB444-to-grayscale frame engine. It shares the color BRAM (12-bit RGB444) and gray BRAM (8-bit) between the AXI host and the internal conversion pipeline. On start, it streams every pixel address through a fixed-latency read → convert → write pipeline, then pulses done. It sits between the AXI register/bridge logic and the two frame BRAMs, replacing ad-hoc select muxing.

Parameters:
IMG_W, 320, frame width in pixels
IMG_H, 240, frame height in pixels
ADDR_W, 17, BRAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
RD_LAT, 1, color BRAM read latency in cycles (1..3)

Ports:
i_CLK  in  1  system clock
i_RST  in  1  synchronous reset, active high
i_HOST_SEL  in  1  host requests ownership of both BRAMs
i_START  in  1  one-cycle start pulse for frame conversion
i_HOST_COLOR_WE  in  1  host color write strobe
i_HOST_COLOR_ADDR  in  ADDR_W  host color write address
i_HOST_COLOR_WDATA  in  12  host pixel {R[3:0],G[3:0],B[3:0]}
i_HOST_GRAY_RE  in  1  host gray read strobe
i_HOST_GRAY_ADDR  in  ADDR_W  host gray read address
o_HOST_GRAY_RDATA  out  8  gray BRAM read data, passed through to host
o_COLOR_ADDR  out  ADDR_W  color BRAM address
o_COLOR_WE  out  1  color BRAM write enable
o_COLOR_WDATA  out  12  color BRAM write data
i_COLOR_RDATA  in  12  color BRAM read data
o_GRAY_ADDR  out  ADDR_W  gray BRAM address
o_GRAY_WE  out  1  gray BRAM write enable
o_GRAY_WDATA  out  8  gray BRAM write data
i_GRAY_RDATA  in  8  gray BRAM read data
o_HOST_GNT  out  1  host currently owns the BRAMs
o_BUSY  out  1  conversion in progress (RUN or DRAIN)
o_DONE  out  1  one-cycle pulse when the last gray pixel is written

Behaviour:
- Clock and reset: one clock, i_CLK. Reset is synchronous and active-high on i_RST.
- Reset values:
  - state = IDLE
  - all outputs 0, including o_HOST_GNT, addresses and write data
  - pipeline valid bits cleared
- Frame size: N = IMG_W*IMG_H.
- States: IDLE, HOST, RUN, DRAIN, DONE.
- IDLE:
  - i_HOST_SEL=1 → HOST.
  - Otherwise, i_START=1 → RUN, with the read counter cleared.
  - If i_HOST_SEL and i_START are high in the same cycle, HOST wins and the start is dropped.
- HOST:
  - o_HOST_GNT=1.
  - Host signals drive the BRAM ports combinationally: o_COLOR_*, and o_GRAY_ADDR = i_HOST_GRAY_ADDR.
  - o_GRAY_WE=0.
  - i_START is ignored.
  - i_HOST_SEL=0 → IDLE.
- RUN:
  - Each cycle, drive o_COLOR_ADDR = rd_cnt with o_COLOR_WE=0, then increment rd_cnt.
  - Issue address N-1 → DRAIN.
  - Host strobes are ignored: writes are dropped and reads return undefined data.
  - i_HOST_SEL has no effect until the next IDLE.
- Pipeline:
  - Address and valid are delayed RD_LAT cycles to align with i_COLOR_RDATA.
  - Data is expanded to 8 bits per channel: r8={R,R}, g8={G,G}, b8={B,B}.
  - Y = (77*r8 + 150*g8 + 29*b8) >> 8. The sum is held in 16 bits unsigned; the coefficients sum to 256, so there is no overflow.
  - Y and the address are registered once. The following cycle drives o_GRAY_WE=1, o_GRAY_ADDR, o_GRAY_WDATA.
  - Write latency from read issue = RD_LAT+1 cycles.
  - Writes are strictly in address order, one per cycle, with no gaps.
- DRAIN: no new reads. When the pipeline is empty after the write of N-1 → DONE.
- DONE: o_DONE=1 for exactly one cycle, then → IDLE.
- Timing: start sampled at cycle 0 → read of address k at cycle k+1 → write of address k at cycle k+RD_LAT+2 → o_DONE at cycle N+RD_LAT+2.
- o_BUSY=1 in RUN and DRAIN only.
- i_START during RUN/DRAIN/DONE: ignored, with no re-trigger.
- Reset mid-run:
  - Returns to IDLE next edge.
  - Pipeline flushed; no further gray writes.
  - o_DONE is not asserted.
- Counter: rd_cnt never exceeds N-1 and does not wrap.

Optional Feature:
Macro FRAME_CTRL_ABORT_EN.
- Defined:
  - Adds input i_ABORT (1 bit).
  - i_ABORT=1 in RUN or DRAIN → IDLE next edge, pipeline flushed, no further gray writes.
  - o_DONE not pulsed; sticky output o_ABORTED=1 until the next accepted i_START or reset.
  - In other states i_ABORT is ignored.
- Not defined: no i_ABORT or o_ABORTED ports; a run always completes.

Test Plan:
- Host write then grant release: HOST_SEL=1, write 0xFFF@0, 0x000@1, 0xF00@2, 0x0F0@3, 0x00F@4 → o_COLOR_WE follows host, o_HOST_GNT=1; HOST_SEL=0 → GNT=0 next cycle.
- Full conversion with RD_LAT=1, using the pixels above and N=320*240:
  - gray@0..4 = 255, 0, 76, 149, 28
  - o_DONE single pulse at cycle 76803 after start
  - o_BUSY high 76802 cycles
  - exactly 76800 gray writes in ascending order
- Arbitration: HOST_SEL and START both asserted in IDLE → HOST entered, no run. HOST_SEL raised during RUN → GNT stays 0 until after DONE, and host write during RUN never reaches o_COLOR_WE.
- Repeated START pulses during RUN → single run, single o_DONE.
- i_RST asserted at write address 1000 → o_GRAY_WE=0 from next cycle, all outputs 0, no o_DONE; new START runs a full frame correctly.
- With FRAME_CTRL_ABORT_EN defined: i_ABORT at read address 500 → no writes after pipeline flush cycle, o_ABORTED=1, no o_DONE; next START clears o_ABORTED.

Source files
------------

// File: rtl/rgb2gray_frame_ctrl_if.sv
// ============================================================================
// Module      : rgb2gray_frame_ctrl_if
// Description : Host bus and frame-BRAM port bundle for rgb2gray_frame_ctrl.
//               Abort signals exist only when FRAME_CTRL_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb2gray_frame_ctrl_if #(
    parameter int ADDR_W = 17
);
`ifdef FRAME_CTRL_ABORT_EN
    logic              i_ABORT;
    logic              o_ABORTED;
`endif
    logic              i_HOST_SEL;
    logic              i_START;
    logic              i_HOST_COLOR_WE;
    logic [ADDR_W-1:0] i_HOST_COLOR_ADDR;
    logic [11:0]       i_HOST_COLOR_WDATA;
    logic              i_HOST_GRAY_RE;
    logic [ADDR_W-1:0] i_HOST_GRAY_ADDR;
    logic [7:0]        o_HOST_GRAY_RDATA;
    logic [ADDR_W-1:0] o_COLOR_ADDR;
    logic              o_COLOR_WE;
    logic [11:0]       o_COLOR_WDATA;
    logic [11:0]       i_COLOR_RDATA;
    logic [ADDR_W-1:0] o_GRAY_ADDR;
    logic              o_GRAY_WE;
    logic [7:0]        o_GRAY_WDATA;
    logic [7:0]        i_GRAY_RDATA;
    logic              o_HOST_GNT;
    logic              o_BUSY;
    logic              o_DONE;

    // Environment side: host logic plus the two BRAMs
    modport master (
`ifdef FRAME_CTRL_ABORT_EN
        output i_ABORT,
        input  o_ABORTED,
`endif
        output i_HOST_SEL, i_START, i_HOST_COLOR_WE, i_HOST_COLOR_ADDR,
        output i_HOST_COLOR_WDATA, i_HOST_GRAY_RE, i_HOST_GRAY_ADDR,
        output i_COLOR_RDATA, i_GRAY_RDATA,
        input  o_HOST_GRAY_RDATA, o_COLOR_ADDR, o_COLOR_WE, o_COLOR_WDATA,
        input  o_GRAY_ADDR, o_GRAY_WE, o_GRAY_WDATA,
        input  o_HOST_GNT, o_BUSY, o_DONE
    );

    modport slave (
`ifdef FRAME_CTRL_ABORT_EN
        input  i_ABORT,
        output o_ABORTED,
`endif
        input  i_HOST_SEL, i_START, i_HOST_COLOR_WE, i_HOST_COLOR_ADDR,
        input  i_HOST_COLOR_WDATA, i_HOST_GRAY_RE, i_HOST_GRAY_ADDR,
        input  i_COLOR_RDATA, i_GRAY_RDATA,
        output o_HOST_GRAY_RDATA, o_COLOR_ADDR, o_COLOR_WE, o_COLOR_WDATA,
        output o_GRAY_ADDR, o_GRAY_WE, o_GRAY_WDATA,
        output o_HOST_GNT, o_BUSY, o_DONE
    );
endinterface

`default_nettype wire

// File: rtl/rgb2gray_frame_ctrl.sv
// ============================================================================
// Module      : rgb2gray_frame_ctrl
// Description : Frame sequencer and BRAM arbiter for RGB444 -> 8-bit gray.
//               Optional run abort enabled by macro FRAME_CTRL_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb2gray_frame_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    rgb2gray_frame_ctrl_if.slave  bus
);

    localparam int                c_N    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOST  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [RD_LAT-1:0] vld_pipe_q;
    logic [ADDR_W-1:0] addr_pipe_q [RD_LAT];
    logic              wr_vld_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              host_rd_q;

    logic              w_issue;
    logic              w_flush;
    logic              w_start_acc;
    logic              w_abort;

`ifdef FRAME_CTRL_ABORT_EN
    logic              aborted_q;
    assign w_abort       = bus.i_ABORT;
    assign bus.o_ABORTED = aborted_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST || w_start_acc) begin
            aborted_q <= 1'b0;
        end else if (w_flush) begin
            aborted_q <= 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Host ownership beats a simultaneous start; that start is lost
                if (bus.i_HOST_SEL) begin
                    state_d = S_HOST;
                end else if (bus.i_START) begin
                    state_d     = S_RUN;
                    rd_cnt_d    = '0;
                    w_start_acc = 1'b1;
                end
            end
            S_HOST: begin
                if (!bus.i_HOST_SEL) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                if (w_abort) begin
                    state_d = S_IDLE;
                    w_flush = 1'b1;
                end else if (rd_cnt_q == c_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    state_d = S_IDLE;
                    w_flush = 1'b1;
                end else if (wr_vld_q && (wr_addr_q == c_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RGB444 expanded by nibble replication, then BT.601-style weights summing to 256
    logic [7:0]  w_r8, w_g8, w_b8;
    logic [15:0] w_sum;
    assign w_r8  = {bus.i_COLOR_RDATA[11:8], bus.i_COLOR_RDATA[11:8]};
    assign w_g8  = {bus.i_COLOR_RDATA[7:4],  bus.i_COLOR_RDATA[7:4]};
    assign w_b8  = {bus.i_COLOR_RDATA[3:0],  bus.i_COLOR_RDATA[3:0]};
    assign w_sum = 16'd77 * {8'd0, w_r8} + 16'd150 * {8'd0, w_g8} + 16'd29 * {8'd0, w_b8};

    always_ff @(posedge i_CLK) begin
        if (i_RST || w_flush) begin
            vld_pipe_q <= '0;
            wr_vld_q   <= 1'b0;
        end else begin
            vld_pipe_q[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            wr_vld_q <= vld_pipe_q[RD_LAT-1];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
            wr_addr_q <= '0;
            wr_data_q <= '0;
            host_rd_q <= 1'b0;
        end else begin
            addr_pipe_q[0] <= rd_cnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
            wr_addr_q <= addr_pipe_q[RD_LAT-1];
            wr_data_q <= w_sum[15:8];
            host_rd_q <= (state_q == S_HOST) && bus.i_HOST_GRAY_RE;
        end
    end

    always_comb begin
        bus.o_COLOR_ADDR  = '0;
        bus.o_COLOR_WE    = 1'b0;
        bus.o_COLOR_WDATA = '0;
        bus.o_GRAY_ADDR   = '0;
        bus.o_GRAY_WE     = 1'b0;
        bus.o_GRAY_WDATA  = '0;
        case (state_q)
            S_HOST: begin
                bus.o_COLOR_ADDR  = bus.i_HOST_COLOR_ADDR;
                bus.o_COLOR_WE    = bus.i_HOST_COLOR_WE;
                bus.o_COLOR_WDATA = bus.i_HOST_COLOR_WDATA;
                bus.o_GRAY_ADDR   = bus.i_HOST_GRAY_ADDR;
            end
            S_RUN: begin
                bus.o_COLOR_ADDR = rd_cnt_q;
            end
            default: begin
            end
        endcase
        if (state_q != S_HOST && wr_vld_q) begin
            bus.o_GRAY_WE    = 1'b1;
            bus.o_GRAY_ADDR  = wr_addr_q;
            bus.o_GRAY_WDATA = wr_data_q;
        end
    end

    // Read data stays visible one cycle past a host read so a late release does not lose it
    assign bus.o_HOST_GRAY_RDATA = ((state_q == S_HOST) || host_rd_q) ? bus.i_GRAY_RDATA : 8'd0;
    assign bus.o_HOST_GNT        = (state_q == S_HOST);
    assign bus.o_BUSY            = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.o_DONE            = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray_frame_ctrl.sv
// ============================================================================
// Module      : tb_rgb2gray_frame_ctrl
// Description : Randomized scoreboard bench for rgb2gray_frame_ctrl with
//               behavioural BRAMs; abort checks active with FRAME_CTRL_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb2gray_frame_ctrl;

    localparam int IMG_W  = 20;
    localparam int IMG_H  = 12;
    localparam int ADDR_W = 17;
    localparam int RD_LAT = 1;
    localparam int N      = IMG_W * IMG_H;
    localparam int PER    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rgb2gray_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rgb2gray_frame_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus  (bus)
    );

    always #(PER/2) clk = ~clk;

    // Behavioural BRAMs: color with RD_LAT read latency, gray with one
    logic [11:0] cmem [0:(1<<ADDR_W)-1];
    logic [7:0]  gmem [0:(1<<ADDR_W)-1];
    logic [11:0] crd  [RD_LAT];
    logic [7:0]  grd;

    always @(posedge clk) begin
        if (bus.o_COLOR_WE) cmem[bus.o_COLOR_ADDR] <= bus.o_COLOR_WDATA;
        crd[0] <= cmem[bus.o_COLOR_ADDR];
        for (int i = 1; i < RD_LAT; i++) crd[i] <= crd[i-1];
        if (bus.o_GRAY_WE) gmem[bus.o_GRAY_ADDR] <= bus.o_GRAY_WDATA;
        grd <= gmem[bus.o_GRAY_ADDR];
    end
    assign bus.i_COLOR_RDATA = crd[RD_LAT-1];
    assign bus.i_GRAY_RDATA  = grd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pixel -> gray straight from the channel arithmetic
    logic [11:0] ref_color [N];

    function automatic int ref_y(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]) * 17;
        g = int'(p[7:4])  * 17;
        b = int'(p[3:0])  * 17;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    typedef struct {
        int     addr;
        int     data;
        longint t;
    } exp_t;
    exp_t q[$];

    int     done_cnt = 0;
    int     busy_cnt = 0;
    int     last_wr  = -1;
    longint done_t   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_GRAY_WE) begin
            last_wr = int'(bus.o_GRAY_ADDR);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL gray_write: unexpected write addr %0d data %0d expected none",
                         bus.o_GRAY_ADDR, bus.o_GRAY_WDATA);
            end else begin
                e = q.pop_front();
                chk("gray_addr", bus.o_GRAY_ADDR, e.addr);
                chk("gray_data", bus.o_GRAY_WDATA, e.data);
                chk("gray_time", $time, e.t);
            end
        end
        if (bus.o_BUSY) begin
            busy_cnt++;
            if (bus.o_COLOR_WE || bus.o_HOST_GNT) begin
                total++;
                bad++;
                $display("FAIL busy_isolation: color_we=%0d gnt=%0d expected 0 0",
                         bus.o_COLOR_WE, bus.o_HOST_GNT);
            end
        end
        if (bus.o_DONE) begin
            done_cnt++;
            done_t = $time;
        end
    end

    int     done_before;
    longint exp_done_t;

    // Call at negedge+1; returns at posedge+1 after the start edge
    task automatic start_frame();
        longint t0;
        bus.i_START = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 bus.i_START = 1'b0;
        busy_cnt    = 0;
        done_before = done_cnt;
        exp_done_t  = t0 + longint'(N + RD_LAT + 1) * PER + PER / 2;
        for (int k = 0; k < N; k++) begin
            q.push_back('{addr: k, data: ref_y(ref_color[k]),
                          t: t0 + longint'(k + RD_LAT + 1) * PER + PER / 2});
        end
    endtask

    task automatic wait_done(input bit noisy);
        bit seen = 1'b0;
        for (int i = 0; i < N + 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != done_before) begin
                seen = 1'b1;
            end else if (noisy) begin
                bus.i_START             = 1'($urandom_range(0, 1));
                bus.i_HOST_SEL          = 1'b1;
                bus.i_HOST_COLOR_WE     = 1'($urandom_range(0, 1));
                bus.i_HOST_COLOR_ADDR   = ADDR_W'($urandom_range(0, N - 1));
                bus.i_HOST_COLOR_WDATA  = 12'($urandom);
            end
        end
        bus.i_START         = 1'b0;
        bus.i_HOST_COLOR_WE = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", N + 40);
        end
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_done_count"}, done_cnt - done_before, 1);
        chk({tag, "_done_time"}, done_t, exp_done_t);
        chk({tag, "_busy_cycles"}, busy_cnt, N + RD_LAT + 1);
        chk({tag, "_writes_left"}, q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_single"}, bus.o_DONE, 0);
        #1;
    endtask

    task automatic host_fill(input int from);
        for (int a = from; a < N; a++) begin
            logic [11:0] d;
            d = 12'($urandom);
            bus.i_HOST_COLOR_WE    = 1'b1;
            bus.i_HOST_COLOR_ADDR  = ADDR_W'(a);
            bus.i_HOST_COLOR_WDATA = d;
            ref_color[a]           = d;
            @(negedge clk);
            #1;
        end
        bus.i_HOST_COLOR_WE = 1'b0;
    endtask

    logic [11:0] pat  [5];
    int          gexp [5];

    initial begin
        pat  = '{12'hFFF, 12'h000, 12'hF00, 12'h0F0, 12'h00F};
        gexp = '{255, 0, 76, 149, 28};

        bus.i_HOST_SEL         = 1'b0;
        bus.i_START            = 1'b0;
        bus.i_HOST_COLOR_WE    = 1'b0;
        bus.i_HOST_COLOR_ADDR  = '0;
        bus.i_HOST_COLOR_WDATA = '0;
        bus.i_HOST_GRAY_RE     = 1'b0;
        bus.i_HOST_GRAY_ADDR   = '0;
`ifdef FRAME_CTRL_ABORT_EN
        bus.i_ABORT            = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.o_HOST_GNT, 0);
        chk("rst_busy", bus.o_BUSY, 0);
        chk("rst_done", bus.o_DONE, 0);
        chk("rst_color", {bus.o_COLOR_WE, bus.o_COLOR_ADDR, bus.o_COLOR_WDATA}, 0);
        chk("rst_gray", {bus.o_GRAY_WE, bus.o_GRAY_ADDR, bus.o_GRAY_WDATA}, 0);
        chk("rst_host_rdata", bus.o_HOST_GRAY_RDATA, 0);
`ifdef FRAME_CTRL_ABORT_EN
        chk("rst_aborted", bus.o_ABORTED, 0);
`endif
        #1 rst = 1'b0;

        // HOST_SEL and START together: host wins, no run
        bus.i_HOST_SEL = 1'b1;
        bus.i_START    = 1'b1;
        @(negedge clk);
        chk("arb_gnt", bus.o_HOST_GNT, 1);
        chk("arb_busy", bus.o_BUSY, 0);
        #1 bus.i_START = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bus.i_HOST_COLOR_WE    = 1'b1;
            bus.i_HOST_COLOR_ADDR  = ADDR_W'(i);
            bus.i_HOST_COLOR_WDATA = pat[i];
            ref_color[i]           = pat[i];
            @(negedge clk);
            chk("host_color_we", bus.o_COLOR_WE, 1);
            chk("host_color_addr", bus.o_COLOR_ADDR, i);
            chk("host_color_wdata", bus.o_COLOR_WDATA, pat[i]);
            #1;
        end
        host_fill(5);
        bus.i_HOST_SEL = 1'b0;
        @(negedge clk);
        chk("release_gnt", bus.o_HOST_GNT, 0);
        repeat (4) @(negedge clk);
        chk("no_run_after_drop", bus.o_BUSY, 0);
        #1;

        // Full frame with repeated STARTs and host activity during the run
        start_frame();
        wait_done(1'b1);
        check_run("run1");
        for (int i = 0; i < 5; i++) chk("gray_pattern", gmem[i], gexp[i]);
        @(negedge clk);
        chk("gnt_after_done", bus.o_HOST_GNT, 1);
        #1;
        bus.i_HOST_GRAY_RE   = 1'b1;
        bus.i_HOST_GRAY_ADDR = ADDR_W'(2);
        @(negedge clk);
        chk("host_gray_addr", bus.o_GRAY_ADDR, 2);
        chk("host_gray_we", bus.o_GRAY_WE, 0);
        @(negedge clk);
        chk("host_gray_rdata", bus.o_HOST_GRAY_RDATA, ref_y(ref_color[2]));
        #1 bus.i_HOST_GRAY_RE = 1'b0;

        // New random frame, then reset in the middle of writing it
        host_fill(0);
        bus.i_HOST_SEL = 1'b0;
        @(negedge clk);
        #1;
        start_frame();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < N + 20 && !hit; i++) begin
                @(negedge clk);
                if (bus.o_GRAY_WE && bus.o_GRAY_ADDR == ADDR_W'(100)) hit = 1'b1;
            end
            chk("rst_point_reached", hit, 1);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 q.delete();
        @(negedge clk);
        chk("midrst_gray_we", bus.o_GRAY_WE, 0);
        chk("midrst_outputs", {bus.o_BUSY, bus.o_DONE, bus.o_HOST_GNT, bus.o_COLOR_ADDR}, 0);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt, done_before);
        #1;
        start_frame();
        wait_done(1'b0);
        check_run("run2");

`ifdef FRAME_CTRL_ABORT_EN
        start_frame();
        begin
            bit hit = 1'b0;
            longint ta;
            for (int i = 0; i < N + 20 && !hit; i++) begin
                @(negedge clk);
                if (bus.o_BUSY && bus.o_COLOR_ADDR == ADDR_W'(50)) hit = 1'b1;
            end
            chk("abort_point_reached", hit, 1);
            #1 bus.i_ABORT = 1'b1;
            @(posedge clk);
            ta = $time;
            #1 bus.i_ABORT = 1'b0;
            while (q.size() > 0 && q[$].t > ta) void'(q.pop_back());
        end
        repeat (RD_LAT + 4) @(negedge clk);
        chk("abort_last_write", last_wr, 50 - (RD_LAT + 1));
        chk("abort_writes_left", q.size(), 0);
        chk("abort_flag", bus.o_ABORTED, 1);
        chk("abort_no_done", done_cnt, done_before);
        chk("abort_busy", bus.o_BUSY, 0);
        #1;
        start_frame();
        @(negedge clk);
        chk("abort_cleared", bus.o_ABORTED, 0);
        #1;
        wait_done(1'b0);
        check_run("run3");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
